// File: rtl/ahb_enum.sv
// Shared AHB-Lite encodings used by peripheral slaves on the matrix.
package ahb_enum;

  typedef enum logic [1:0] {
    AHB_RESP_OKAY  = 2'b00,
    AHB_RESP_ERROR = 2'b01,
    AHB_RESP_RETRY = 2'b10,
    AHB_RESP_SPLIT = 2'b11
  } ahb_resp_e;

endpackage

// File: rtl/mbox_pkg.sv
// Register map and field layouts for the multi-channel AHB mailbox.
package mbox_pkg;

  localparam logic [7:0] OFF_DATA      = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
  localparam logic [7:0] OFF_INTR_EN   = 8'h08;
  localparam logic [7:0] OFF_INTR_STAT = 8'h0C;
  localparam logic [7:0] OFF_THRESH    = 8'h10;

  localparam int unsigned INTR_THRESH = 0;
  localparam int unsigned INTR_OVF    = 1;
  localparam int unsigned INTR_UDF    = 2;

  typedef struct packed {
    logic udf;
    logic ovf;
    logic thresh;
  } intr_bits_t;

  typedef struct packed {
    logic [13:0] rsvd;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } status_t;

endpackage

// File: rtl/mbox_fifo.sv
// One mailbox channel: word FIFO with occupancy count and overflow/underflow strobes.
module mbox_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          ovf,
  output logic                          udf
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign ovf     = push & full;
  assign udf     = pop & empty;
  assign do_push = push & ~full & ~rst;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ahb_mailbox_mc.sv
// Zero-wait-state AHB-Lite slave exposing NUM_CH mailbox FIFOs with per-channel
// status, threshold and sticky overflow/underflow interrupts.
module ahb_mailbox_mc #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [3:0]            hprot,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [1:0]            hresp,
  output logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic [NUM_CH-1:0]     mailbox_intr
);
  import ahb_enum::*;
  import mbox_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic       ph_valid;
  logic       ph_write;
  logic [3:0] ph_ch;
  logic [7:0] ph_off;

  logic [DATA_WIDTH-1:0] fifo_rdata [NUM_CH];
  logic [CW-1:0]         fifo_count [NUM_CH];
  logic [NUM_CH-1:0]     fifo_full, fifo_empty, fifo_ovf, fifo_udf;
  logic [NUM_CH-1:0]     push, pop, en_we, stat_we, thr_we;
  logic [NUM_CH-1:0]     ovf_q, udf_q;
  logic [2:0]            intr_en_q [NUM_CH];
  logic [15:0]           thresh_q  [NUM_CH];
  intr_bits_t            intr_stat [NUM_CH];
  status_t               status_w  [NUM_CH];
  logic                  unused_ok;

  assign hresp     = AHB_RESP_OKAY;
  assign hready    = 1'b1;
  assign unused_ok = ^{hprot, hsize, htrans[0], haddr, hwdata};

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_ch    <= '0;
      ph_off   <= '0;
    end else begin
      ph_valid <= hsel & htrans[1];
      ph_write <= hwrite;
      ph_ch    <= haddr[11:8];
      ph_off   <= haddr[7:0];
    end
  end

  // Data-phase decode; channels at or above NUM_CH never match, so they read 0 and stay inert.
  always_comb begin
    push    = '0;
    pop     = '0;
    en_we   = '0;
    stat_we = '0;
    thr_we  = '0;
    hrdata  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ph_valid && ph_ch == 4'(c)) begin
        if (ph_write) begin
          case (ph_off)
            OFF_DATA:      push[c]    = 1'b1;
            OFF_INTR_EN:   en_we[c]   = 1'b1;
            OFF_INTR_STAT: stat_we[c] = 1'b1;
            OFF_THRESH:    thr_we[c]  = 1'b1;
            default:       ;
          endcase
        end else begin
          case (ph_off)
            OFF_DATA: begin
              pop[c] = 1'b1;
              hrdata = fifo_empty[c] ? '0 : fifo_rdata[c];
            end
            OFF_STATUS:    hrdata = DATA_WIDTH'(status_w[c]);
            OFF_INTR_EN:   hrdata = DATA_WIDTH'(intr_en_q[c]);
            OFF_INTR_STAT: hrdata = DATA_WIDTH'(intr_stat[c]);
            OFF_THRESH:    hrdata = DATA_WIDTH'(thresh_q[c]);
            default:       ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        intr_en_q[c] <= '0;
        thresh_q[c]  <= '0;
      end
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (en_we[c])  intr_en_q[c] <= hwdata[2:0];
        if (thr_we[c]) thresh_q[c]  <= hwdata[15:0];
        // A fresh event on the clearing edge keeps the sticky bit set.
        ovf_q[c] <= fifo_ovf[c] | (ovf_q[c] & ~(stat_we[c] & hwdata[INTR_OVF]));
        udf_q[c] <= fifo_udf[c] | (udf_q[c] & ~(stat_we[c] & hwdata[INTR_UDF]));
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mbox_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (hclk),
      .rst  (hreset),
      .push (push[c]),
      .pop  (pop[c]),
      .wdata(hwdata),
      .rdata(fifo_rdata[c]),
      .count(fifo_count[c]),
      .full (fifo_full[c]),
      .empty(fifo_empty[c]),
      .ovf  (fifo_ovf[c]),
      .udf  (fifo_udf[c])
    );

    assign status_w[c]  = '{rsvd: '0, full: fifo_full[c], empty: fifo_empty[c],
                            count: 16'(fifo_count[c])};
    assign intr_stat[c] = '{udf: udf_q[c], ovf: ovf_q[c],
                            thresh: (thresh_q[c] != '0) && (16'(fifo_count[c]) >= thresh_q[c])};
    assign mailbox_intr[c] = |(intr_stat[c] & intr_en_q[c]);
  end

endmodule

// File: tb/tb_ahb_mailbox_mc.sv
// Randomized and directed bench for ahb_mailbox_mc against a queue-based mailbox model.
module tb_ahb_mailbox_mc;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [3:0]  hprot = '0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [1:0]  hresp;
  logic        hready;
  logic [31:0] hrdata;
  logic [NCH-1:0] mailbox_intr;

  ahb_mailbox_mc #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_CH    (NCH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hsel        (hsel),
    .haddr       (haddr),
    .hprot       (hprot),
    .hsize       (hsize),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hwdata      (hwdata),
    .hresp       (hresp),
    .hready      (hready),
    .hrdata      (hrdata),
    .mailbox_intr(mailbox_intr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          v;
    bit          wr;
    logic [3:0]  ch;
    logic [7:0]  off;
    logic [31:0] wd;
    bit          lit_en;
    logic [31:0] lit;
  } xfer_t;

  // Behavioural mailbox state
  logic [31:0] mq [NCH][$];
  logic [2:0]  m_en  [NCH];
  logic [15:0] m_thr [NCH];
  bit          m_ovf [NCH];
  bit          m_udf [NCH];

  xfer_t       pend;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_hrdata;
  logic [NCH-1:0] exp_intr;
  bit          exp_lit_en;
  logic [31:0] exp_lit;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_en[c]  = '0;
      m_thr[c] = '0;
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
    end
  endfunction

  function automatic logic [2:0] stat_of(int c);
    bit th;
    th = (m_thr[c] != 0) && (mq[c].size() >= int'(m_thr[c]));
    return {m_udf[c], m_ovf[c], th};
  endfunction

  function automatic logic [31:0] peek(xfer_t p);
    int c;
    if (!p.v || p.wr || int'(p.ch) >= NCH) return 32'h0;
    c = int'(p.ch);
    case (p.off)
      8'h00: return (mq[c].size() == 0) ? 32'h0 : mq[c][0];
      8'h04: return {14'h0, mq[c].size() == DEPTH, mq[c].size() == 0, 16'(mq[c].size())};
      8'h08: return {29'h0, m_en[c]};
      8'h0C: return {29'h0, stat_of(c)};
      8'h10: return {16'h0, m_thr[c]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [NCH-1:0] intr_model();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = |(stat_of(c) & m_en[c]);
    return r;
  endfunction

  function automatic void commit(xfer_t p);
    int c;
    if (!p.v || int'(p.ch) >= NCH) return;
    c = int'(p.ch);
    if (p.wr) begin
      case (p.off)
        8'h00: if (mq[c].size() == DEPTH) m_ovf[c] = 1'b1; else mq[c].push_back(p.wd);
        8'h08: m_en[c] = p.wd[2:0];
        8'h0C: begin
          if (p.wd[1]) m_ovf[c] = 1'b0;
          if (p.wd[2]) m_udf[c] = 1'b0;
        end
        8'h10: m_thr[c] = p.wd[15:0];
        default: ;
      endcase
    end else if (p.off == 8'h00) begin
      if (mq[c].size() == 0) m_udf[c] = 1'b1;
      else void'(mq[c].pop_front());
    end
  endfunction

  function automatic xfer_t mk(bit v, bit wr, logic [3:0] ch, logic [7:0] off,
                               logic [31:0] wd, bit le, logic [31:0] lit);
    xfer_t x;
    x.v = v; x.wr = wr; x.ch = ch; x.off = off; x.wd = wd; x.lit_en = le; x.lit = lit;
    return x;
  endfunction

  // One bus cycle: drive a's address phase plus the pending data phase, then commit at the edge.
  task automatic step(input xfer_t a, input bit rst);
    hreset = rst;
    hsel   = a.v;
    htrans = a.v ? 2'b10 : 2'b00;
    hwrite = a.wr;
    haddr  = {20'h0, a.ch, a.off};
    hwdata = (pend.v && pend.wr) ? pend.wd : $urandom;
    exp_hrdata = peek(pend);
    exp_intr   = intr_model();
    exp_lit_en = pend.lit_en;
    exp_lit    = pend.lit;
    @(posedge hclk);
    #1;
    if (rst) begin
      model_reset();
      pend = mk(0, 0, 0, 0, 0, 0, 0);
    end else begin
      commit(pend);
      pend = a;
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [7:0] off, input logic [31:0] d);
    step(mk(1, 1, ch, off, d, 0, 0), 1'b0);
  endtask

  task automatic rd(input logic [3:0] ch, input logic [7:0] off, input bit le, input logic [31:0] lit);
    step(mk(1, 0, ch, off, 0, le, lit), 1'b0);
  endtask

  task automatic idle();
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      chk("hrdata", hrdata, exp_hrdata);
      chk("mailbox_intr", 32'(mailbox_intr), 32'(exp_intr));
      chk("hready", 32'(hready), 32'h1);
      chk("hresp", 32'(hresp), 32'h0);
      if (exp_lit_en) begin
        chk("pin_model", exp_hrdata, exp_lit);
        chk("pin_dut", hrdata, exp_lit);
      end
    end
  end

  logic [7:0] offs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

  initial begin
    pend = mk(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk_en = 1'b1;
    chk("reset_intr", 32'(mailbox_intr), 32'h0);

    // Reset state of ch0
    rd(0, 8'h04, 1, 32'h0001_0000);
    idle();

    // Ordered traffic on ch1, other channels untouched
    wr(1, 8'h00, 32'hA5A5_0001);
    wr(1, 8'h00, 32'hA5A5_0002);
    wr(1, 8'h00, 32'hA5A5_0003);
    rd(1, 8'h04, 1, 32'h0000_0003);
    rd(1, 8'h00, 1, 32'hA5A5_0001);
    rd(1, 8'h00, 1, 32'hA5A5_0002);
    rd(1, 8'h00, 1, 32'hA5A5_0003);
    rd(1, 8'h04, 1, 32'h0001_0000);
    rd(0, 8'h04, 1, 32'h0001_0000);
    rd(2, 8'h04, 1, 32'h0001_0000);
    rd(3, 8'h04, 1, 32'h0001_0000);
    idle();

    // Threshold interrupt on ch2
    wr(2, 8'h10, 32'd2);
    wr(2, 8'h08, 32'd1);
    wr(2, 8'h00, 32'h1111_0000);
    wr(2, 8'h00, 32'h1111_0001);
    chk("intr2_before", 32'(mailbox_intr[2]), 32'h0);
    idle();
    chk("intr2_rise", 32'(mailbox_intr[2]), 32'h1);
    rd(2, 8'h00, 1, 32'h1111_0000);
    idle();
    chk("intr2_fall", 32'(mailbox_intr[2]), 32'h0);

    // Overflow on ch3
    wr(3, 8'h08, 32'd2);
    for (int i = 0; i <= DEPTH; i++) wr(3, 8'h00, 32'hC0DE_0000 + 32'(i));
    rd(3, 8'h0C, 1, 32'h0000_0002);
    rd(3, 8'h04, 1, 32'h0002_0008);
    idle();
    chk("intr3_ovf", 32'(mailbox_intr[3]), 32'h1);
    wr(3, 8'h0C, 32'h2);
    idle();
    chk("intr3_clr", 32'(mailbox_intr[3]), 32'h0);
    for (int i = 0; i < DEPTH; i++) rd(3, 8'h00, 1, 32'hC0DE_0000 + 32'(i));
    rd(3, 8'h00, 1, 32'h0);

    // Underflow on ch0 and out-of-range channel
    rd(0, 8'h00, 1, 32'h0);
    rd(0, 8'h0C, 1, 32'h0000_0004);
    rd(0, 8'h04, 1, 32'h0001_0000);
    wr(5, 8'h00, 32'hDEAD_BEEF);
    rd(5, 8'h00, 1, 32'h0);
    rd(5, 8'h04, 1, 32'h0);
    idle();

    // Pointer wrap on ch1
    wr(1, 8'h00, $urandom);
    wr(1, 8'h00, $urandom);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      wr(1, 8'h00, $urandom);
      rd(1, 8'h00, 0, 0);
    end

    // Reset while a pop is in its data phase
    rd(1, 8'h00, 0, 0);
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
    rd(1, 8'h04, 1, 32'h0001_0000);
    rd(2, 8'h10, 1, 32'h0);
    rd(3, 8'h0C, 1, 32'h0);
    idle();
    chk("intr_after_rst", 32'(mailbox_intr), 32'h0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      xfer_t a;
      int    k;
      logic [31:0] d;
      k = int'($urandom_range(0, 8));
      a = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 5) > 4 ? 5 : $urandom_range(0, 3)),
             offs[k > 5 ? 0 : k], $urandom, 0, 0);
      if (a.off == 8'h10) begin
        d = 32'($urandom_range(0, 9));
        a.wd = d;
      end
      step(a, $urandom_range(0, 299) == 0);
    end
    idle();
    idle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
